div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request-queue entries (power of two, >=2).
REQ-002 Parameter DIV_LATENCY, default 34, clock cycles from div_start high to valid div_q/div_r.
REQ-003 clock  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on in_a/in_b.
REQ-006 in_ready  output  1  request accepted on a clock edge where in_valid && in_ready.
REQ-007 in_a, in_b  input  32 each  dividend, divisor.
REQ-008 div_start  output  1  start pulse to the downstream divider.
REQ-009 div_a, div_b  output  32 each  operands to divider.
REQ-010 div_q, div_r  input  32 each  quotient, remainder from divider.
REQ-011 res_valid  output  1  result present.
REQ-012 res_ready  input  1  consumer takes result when res_valid && res_ready.
REQ-013 res_q, res_r  output  32 each  result quotient, remainder.
REQ-014 res_dz  output  1  result came from a zero divisor.

Function
REQ-015 Requests are queued in a FIFO_DEPTH-entry FIFO; in_ready = FIFO not full, independent of res_ready.
REQ-016 Push when full is refused (in_ready low); simultaneous push and pop on a full FIFO refuses the push.
REQ-017 FSM states: IDLE, START, WAIT, HOLD.
REQ-018 IDLE -> START when FIFO non-empty; head is popped on that edge and latched into div_a/div_b.
REQ-019 START lasts exactly one cycle with div_start=1; div_start=0 in all other states.
REQ-020 WAIT counts DIV_LATENCY-1 further cycles; div_a/div_b remain stable from START through end of WAIT.
REQ-021 On the last WAIT cycle div_q/div_r are captured into res_q/res_r, res_dz=0; next state HOLD.
REQ-022 HOLD: res_valid=1; res_q/res_r/res_dz stable while res_ready=0; HOLD -> IDLE on res_valid && res_ready.
REQ-023 Only one request outstanding at the divider; next START no earlier than the cycle after result handshake.
REQ-024 Latency, empty FIFO, res_ready=1: accept at edge N, div_start high cycle N+1, res_valid high cycle N+1+DIV_LATENCY.
REQ-025 Requests complete in acceptance order; none dropped or duplicated.

Reset
REQ-026 Reset clears FIFO (empty), FSM to IDLE, counter to 0.
REQ-027 Outputs on reset: in_ready=1, div_start=0, div_a=div_b=0, res_valid=0, res_q=res_r=0, res_dz=0.
REQ-028 Reset mid-WAIT or mid-HOLD discards the in-flight request and all queued requests; late div_q/div_r never captured.

Configuration
REQ-029 Macro DIVSEQ_ZERO_CHECK_EN.
REQ-030 Defined: head with divisor 0 goes IDLE -> HOLD directly, no div_start, res_q=32'hFFFF_FFFF, res_r=dividend, res_dz=1, res_valid the cycle after pop.
REQ-031 Undefined: zero divisor follows the normal START/WAIT path; res_dz tied to 0.

Structure
REQ-032 Shared package divseq_pkg: state enum, DATA_W=32, default DIV_LATENCY and FIFO_DEPTH constants.
REQ-033 One sub-module divseq_fifo (synchronous FIFO, 64-bit entries, full/empty flags, wrap-around pointers with extra bit).

Verification
REQ-034 Accept 100/7, res_ready=1 -> div_start one cycle after accept, res_q=14, res_r=2 DIV_LATENCY cycles after div_start.
REQ-035 Push 6 requests back-to-back with res_ready=0 -> 1 in flight + 4 queued, 6th held with in_ready=0 until first result taken.
REQ-036 Hold res_ready=0 for 10 cycles in HOLD -> res_q/res_r/res_dz unchanged, no new div_start.
REQ-037 With DIVSEQ_ZERO_CHECK_EN, 5/0 -> no div_start, res_q=32'hFFFF_FFFF, res_r=5, res_dz=1; without macro, div_start issued, res_dz=0.
REQ-038 Assert reset for one cycle during WAIT with 2 queued -> next cycle in_ready=1, res_valid=0, div_start=0; no stale result after.
REQ-039 Sequence 1000/10, 7/9, 0xFFFFFFFF/1 -> results in order: (100,0), (0,7), (0xFFFFFFFF,0).

Source files
------------

// File: rtl/divseq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divseq_pkg
// Purpose  : Shared types and constants for the divider request sequencer.
//            Holds the FSM state encoding, the queued request record and the
//            default latency / queue depth used by div_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package divseq_pkg;

   localparam int DATA_W          = 32;
   localparam int DEF_DIV_LATENCY = 34;
   localparam int DEF_FIFO_DEPTH  = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   // One queued request: dividend in the upper half, divisor in the lower.
   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } req_t;

endpackage
`default_nettype wire

// File: rtl/divseq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : divseq_fifo
// Purpose  : Synchronous FIFO with registered pointers that carry one extra
//            wrap bit, so full and empty are told apart without a counter.
//            Read data is the current head (show-ahead).
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_push, i_wdata - write request / data (ignored while full)
//            i_pop           - remove head (ignored while empty)
//            o_rdata         - current head entry
//            o_full, o_empty - occupancy flags
// Revision : 1.0 - initial release
// ============================================================================
module divseq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   // Same index with opposite wrap bit means the writer has lapped the reader.
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_empty = (r_wr_ptr == r_rd_ptr);

   // A push while full is refused even if a pop happens on the same edge.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: it is only read behind a valid pointer pair.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
   end

endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Purpose  : Queues divide requests and feeds them one at a time to an
//            external fixed-latency divider, then holds each result until
//            the consumer takes it.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            in_valid/in_ready       - request handshake
//            in_a, in_b              - dividend, divisor
//            div_start, div_a, div_b - divider start pulse and operands
//            div_q, div_r            - divider quotient / remainder
//            res_valid/res_ready     - result handshake
//            res_q, res_r, res_dz    - result and zero-divisor flag
// Options  : DIVSEQ_ZERO_CHECK_EN - when defined, a zero divisor bypasses the
//            divider and returns q=all ones, r=dividend, res_dz=1.
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer
   import divseq_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int DIV_LATENCY = DEF_DIV_LATENCY
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              div_start,
   output logic [DATA_W-1:0] div_a,
   output logic [DATA_W-1:0] div_b,
   input  logic [DATA_W-1:0] div_q,
   input  logic [DATA_W-1:0] div_r,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_q,
   output logic [DATA_W-1:0] res_r,
   output logic              res_dz
);

   localparam int             CNT_W    = $clog2(DIV_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [DATA_W-1:0]   r_div_a,  w_div_a_nxt;
   logic [DATA_W-1:0]   r_div_b,  w_div_b_nxt;
   logic [DATA_W-1:0]   r_res_q,  w_res_q_nxt;
   logic [DATA_W-1:0]   r_res_r,  w_res_r_nxt;
   logic                r_res_dz, w_res_dz_nxt;

   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic [2*DATA_W-1:0] w_head_raw;
   req_t                w_head;

   divseq_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*DATA_W)
   ) u_fifo (
      .clk     (clock),
      .rst     (reset),
      .i_push  (in_valid),
      .i_wdata ({in_a, in_b}),
      .i_pop   (w_pop),
      .o_rdata (w_head_raw),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head = w_head_raw;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_div_a  <= '0;
         r_div_b  <= '0;
         r_res_q  <= '0;
         r_res_r  <= '0;
         r_res_dz <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_div_a  <= w_div_a_nxt;
         r_div_b  <= w_div_b_nxt;
         r_res_q  <= w_res_q_nxt;
         r_res_r  <= w_res_r_nxt;
         r_res_dz <= w_res_dz_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_div_a_nxt  = r_div_a;
      w_div_b_nxt  = r_div_b;
      w_res_q_nxt  = r_res_q;
      w_res_r_nxt  = r_res_r;
      w_res_dz_nxt = r_res_dz;
      w_pop        = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_div_a_nxt = w_head.a;
               w_div_b_nxt = w_head.b;
`ifdef DIVSEQ_ZERO_CHECK_EN
               if (w_head.b == '0) begin
                  w_state_nxt  = S_HOLD;
                  w_res_q_nxt  = '1;
                  w_res_r_nxt  = w_head.a;
                  w_res_dz_nxt = 1'b1;
               end else begin
                  w_state_nxt  = S_START;
               end
`else
               w_state_nxt = S_START;
`endif
            end
         end

         // The START cycle itself is the first of the DIV_LATENCY cycles,
         // so WAIT begins counting at 1.
         S_START: begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(1);
         end

         S_WAIT: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt  = S_HOLD;
               w_cnt_nxt    = '0;
               w_res_q_nxt  = div_q;
               w_res_r_nxt  = div_r;
               w_res_dz_nxt = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end

         S_HOLD: begin
            if (res_ready) w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign in_ready  = !w_full;
   assign div_start = (r_state == S_START);
   assign div_a     = r_div_a;
   assign div_b     = r_div_b;
   assign res_valid = (r_state == S_HOLD);
   assign res_q     = r_res_q;
   assign res_r     = r_res_r;
   assign res_dz    = r_res_dz;

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sequencer
// Purpose  : Self-checking bench for div_sequencer. Provides a fixed-latency
//            divider model that shows garbage until its result is due, a
//            request source queue, and an in-order result scoreboard.
// Options  : DIVSEQ_ZERO_CHECK_EN - must match the RTL build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

   localparam int L     = 34;
   localparam int DEPTH = 4;
`ifdef DIVSEQ_ZERO_CHECK_EN
   localparam bit ZC = 1'b1;
`else
   localparam bit ZC = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        div_start;
   logic [31:0] div_a, div_b, div_q, div_r;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_q, res_r;
   logic        res_dz;

   always #5 clock = ~clock;

   div_sequencer #(
      .FIFO_DEPTH  (DEPTH),
      .DIV_LATENCY (L)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .div_start (div_start),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_q     (div_q),
      .div_r     (div_r),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_q     (res_q),
      .res_r     (res_r),
      .res_dz    (res_dz)
   );

   // Expected {dz, q, r} for a request, from plain arithmetic.
   function automatic logic [64:0] ref_res(input logic [31:0] a, input logic [31:0] b);
      if (b == 0) return {ZC, 32'hFFFF_FFFF, a};
      return {1'b0, a / b, a % b};
   endfunction

   // Divider model: latches operands on div_start; its outputs are junk until
   // the cycle DIV_LATENCY-1 after the start cycle. It ignores reset, so an
   // abandoned operation keeps running and later looks like a valid answer.
   int unsigned dv_cnt = 0;
   logic [31:0] dv_a = '0;
   logic [31:0] dv_b = '0;
   logic [64:0] dv_res;
   always @(posedge clock) begin
      if (div_start) begin
         dv_cnt <= 1;
         dv_a   <= div_a;
         dv_b   <= div_b;
      end else if (dv_cnt != 0 && dv_cnt < 1000) begin
         dv_cnt <= dv_cnt + 1;
      end
   end
   assign dv_res = ref_res(dv_a, dv_b);
   assign {div_q, div_r} = (dv_cnt >= L - 1) ? dv_res[63:0] : {32'hDEAD_BEEF, 32'hBAD0_BAD0};

   logic [63:0] src[$];
   logic [64:0] sb[$];
   int checks = 0;
   int errors = 0;
   int n_acc = 0;
   int n_start = 0;
   bit outstanding = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", nm, act, exp);
      end
   endtask

   // One clock: drive from the source queue, note handshakes that the coming
   // edge will perform, then advance to the next falling edge.
   task automatic tick();
      logic [64:0] e;
      if (src.size() > 0) begin
         in_valid = 1'b1;
         {in_a, in_b} = src[0];
      end else begin
         in_valid = 1'b0;
      end
      if (reset) begin
         sb.delete();
         outstanding = 1'b0;
      end else begin
         if (div_start) begin
            chk("single_outstanding", outstanding, 0);
            outstanding = 1'b1;
            n_start++;
         end else if (outstanding && !res_valid) begin
            chk("div_operand_stable", {div_a, div_b}, {dv_a, dv_b});
         end
         if (in_valid && in_ready) begin
            sb.push_back(ref_res(in_a, in_b));
            void'(src.pop_front());
            n_acc++;
         end
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", {res_dz, res_q, res_r}, 0);
            end else begin
               e = sb.pop_front();
               chk("result_order", {res_dz, res_q, res_r}, e);
            end
            outstanding = 1'b0;
         end
      end
      @(negedge clock);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
   } vec_t;

   vec_t tv[8];

   initial begin
      int k, n0, stray, pushed;
      logic [64:0] held;

      tv[0] = '{32'd100,        32'd7,  32'd14,          32'd2};
      tv[1] = '{32'd1000,       32'd10, 32'd100,         32'd0};
      tv[2] = '{32'd7,          32'd9,  32'd0,           32'd7};
      tv[3] = '{32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,   32'd0};
      tv[4] = '{32'd5,          32'd0,  32'hFFFF_FFFF,   32'd5};
      tv[5] = '{32'd0,          32'd3,  32'd0,           32'd0};
      tv[6] = '{32'h8000_0000,  32'd3,  32'd715827882,   32'd2};
      tv[7] = '{32'd12345,      32'd12345, 32'd1,        32'd0};

      repeat (3) @(negedge clock);
      chk("reset_flags", {in_ready, div_start, res_valid, res_dz}, 4'b1000);
      chk("reset_data", {div_a, div_b, res_q, res_r}, 128'd0);
      reset = 1'b0;
      tick();

      // Single requests on an empty queue: latency and value per vector.
      for (int i = 0; i < 8; i++) begin
         res_ready = 1'b1;
         src.push_back({tv[i].a, tv[i].b});
         k = 0;
         while (src.size() > 0 && k < 20) begin tick(); k++; end
         chk("vec_accept", src.size(), 0);
         chk("vec_no_early_start", div_start, 0);
         tick();
         if (ZC && tv[i].b == 0) begin
            chk("zero_bypass", {res_valid, div_start}, 2'b10);
         end else begin
            chk("start_latency", div_start, 1);
            k = 0;
            while (!res_valid && k < L + 10) begin tick(); k++; end
            chk("result_latency", k, L);
         end
         chk("vec_result", {res_dz, res_q, res_r}, {ZC && (tv[i].b == 0), tv[i].q, tv[i].r});
         tick();
      end

      // Back-pressure: six requests, no consumer. One goes to the divider,
      // four fill the queue, the sixth waits.
      res_ready = 1'b0;
      repeat (4) tick();
      n0 = n_acc;
      for (int i = 0; i < 6; i++) src.push_back({32'(100 + i * 13), 32'(i + 3)});
      repeat (12) tick();
      chk("accepted_until_full", n_acc - n0, 5);
      chk("in_ready_when_full", in_ready, 0);
      k = 0;
      while (!res_valid && k < L + 10) begin tick(); k++; end
      chk("first_result_arrives", res_valid, 1);
      held = {res_dz, res_q, res_r};
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_stable", {res_valid, res_dz, res_q, res_r}, {1'b1, held});
         chk("hold_no_start", div_start, 0);
      end
      chk("sixth_still_held", src.size(), 1);
      res_ready = 1'b1;
      k = 0;
      while (src.size() > 0 && k < 10) begin tick(); k++; end
      chk("sixth_accepted_after_take", src.size(), 0);
      k = 0;
      while (sb.size() > 0 && k < 2000) begin tick(); k++; end
      chk("backpressure_drain", sb.size(), 0);
      repeat (3) tick();

      // Reset in the middle of WAIT with two requests still queued.
      n0 = n_start;
      src.push_back({32'd900, 32'd4});
      src.push_back({32'd901, 32'd5});
      src.push_back({32'd902, 32'd6});
      k = 0;
      while (n_start == n0 && k < 20) begin tick(); k++; end
      repeat (5) tick();
      chk("reset_test_queued", {src.size(), sb.size()}, {32'd0, 32'd3});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("post_reset", {in_ready, res_valid, div_start}, 3'b100);
      stray = 0;
      for (int i = 0; i < 2 * L; i++) begin
         if (res_valid || div_start) stray++;
         tick();
      end
      chk("no_stale_after_reset", stray, 0);
      src.push_back({32'd40, 32'd6});
      k = 0;
      while ((src.size() > 0 || sb.size() > 0) && k < 200) begin tick(); k++; end
      chk("after_reset_request", {src.size(), sb.size()}, 64'd0);

      // Random stream with random consumer stalls.
      n0 = n_acc;
      pushed = 0;
      k = 0;
      while ((pushed < 25 || src.size() > 0 || sb.size() > 0) && k < 6000) begin
         res_ready = ($urandom_range(0, 2) != 0);
         if (pushed < 25 && src.size() < 2 && $urandom_range(0, 3) == 0) begin
            src.push_back({$urandom(),
                           ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom()});
            pushed++;
         end
         tick();
         k++;
      end
      chk("random_drain", {src.size(), sb.size()}, 64'd0);
      chk("random_count", n_acc - n0, 25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
